// File: rtl/data_mem_responder.sv
// Latency-programmable 64-bit data memory responder with a valid/ready request and response handshake.
// Optional build macro DATA_MEM_ALIGN_CHECK_EN rejects accesses whose byte address is not 8-byte aligned.
module data_mem_responder #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic        cap_write;
  logic [63:0] cap_addr;
  logic [63:0] cap_wdata;
  logic [63:0] mem [DEPTH];

  logic          accept;
  logic          resp_edge;
  logic [AW-1:0] cap_index;
  logic          out_of_range;
  logic          misaligned;
  logic          cap_err;

  assign accept    = (state == IDLE) && req_valid;
  assign resp_edge = (state == WAIT) && (cnt == 4'd0);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Decode the captured copy so input changes after accept cannot alter the access.
  assign cap_index    = cap_addr[AW+2:3];
  assign out_of_range = |cap_addr[63:AW+3];

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign misaligned = |cap_addr[2:0];
`else
  logic unused_byte_offset;
  assign misaligned         = 1'b0;
  assign unused_byte_offset = ^cap_addr[2:0];
`endif

  assign cap_err = out_of_range | misaligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      // NOTE: every register in clocked blocks uses <= so all state updates see pre-edge values.
      state <= next_state;
    end
  end

  always_comb begin
    // NOTE: the default assignment first keeps next_state driven on every path, so no latch forms.
    next_state = state;
    unique case (state)
      IDLE: if (req_valid) next_state = WAIT;
      WAIT: if (cnt == 4'd0) next_state = RESP;
      RESP: if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 4'd0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      cnt       <= 4'(LATENCY - 1);
      cap_write <= req_write;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the storage must read as zero after reset, so it is a register array cleared here, not a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (resp_edge && cap_write && !cap_err) begin
      mem[cap_index] <= cap_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (resp_edge) begin
      rsp_rdata <= (cap_write || cap_err) ? 64'd0 : mem[cap_index];
      rsp_err   <= cap_err;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2/DEPTH=32 instance and a LATENCY=1/DEPTH=4 instance.
module tb_data_mem_responder;

  localparam int DEPTH = 32;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [63:0] req_addr, req_wdata, rsp_rdata;

  logic        q_req_valid, q_req_ready, q_req_write, q_rsp_valid, q_rsp_ready, q_rsp_err;
  logic [63:0] q_req_addr, q_req_wdata, q_rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  data_mem_responder #(.DEPTH(4), .LATENCY(1)) dut_lat1 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (q_req_valid),
    .req_ready (q_req_ready),
    .req_write (q_req_write),
    .req_addr  (q_req_addr),
    .req_wdata (q_req_wdata),
    .rsp_valid (q_rsp_valid),
    .rsp_ready (q_rsp_ready),
    .rsp_rdata (q_rsp_rdata),
    .rsp_err   (q_rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the main instance; garbage is driven on the request
  // side and rsp_ready is held high while waiting, neither of which may matter.
  task automatic txn(input string tag, input logic wr, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [63:0] exp_rdata,
                     input logic exp_err, input int hold);
    int lat;
    check({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    req_write = ~wr;
    req_addr  = 64'($urandom_range(DEPTH - 1, 0)) << 3;
    req_wdata = {$urandom, $urandom};
    rsp_ready = 1'b1;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      check({tag, " req_ready wait"}, 64'(req_ready), 64'd0);
      step();
      lat++;
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check({tag, " latency"}, 64'(lat), 64'(LAT));
    check({tag, " rdata"}, rsp_rdata, exp_rdata);
    check({tag, " err"}, 64'(rsp_err), 64'(exp_err));
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, " hold valid"}, 64'(rsp_valid), 64'd1);
      check({tag, " hold rdata"}, rsp_rdata, exp_rdata);
      check({tag, " hold req_ready"}, 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, " done valid"}, 64'(rsp_valid), 64'd0);
    check({tag, " done req_ready"}, 64'(req_ready), 64'd1);
    check({tag, " done rdata"}, rsp_rdata, 64'd0);
    check({tag, " done err"}, 64'(rsp_err), 64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    rsp_ready   = 1'b0;
    q_req_valid = 1'b0;
    q_req_write = 1'b0;
    q_req_addr  = '0;
    q_req_wdata = '0;
    q_rsp_ready = 1'b0;
    #2;
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp_rdata", rsp_rdata, 64'd0);
    check("reset rsp_err", 64'(rsp_err), 64'd0);
    step();
    step();
    reset = 1'b0;

    // First accept right after reset, with five cycles of backpressure.
    txn("bp load 0x0", 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 5);

    txn("store 0x10", 1'b1, 64'h10, 64'h1122334455667788, 64'h0, 1'b0, 0);
    txn("load 0x10", 1'b0, 64'h10, 64'h0, 64'h1122334455667788, 1'b0, 0);

    txn("oor store 0x100", 1'b1, 64'h100, 64'hFF, 64'h0, 1'b1, 0);
    txn("load 0x0 after oor", 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 0);
    txn("oor high bit", 1'b1, 64'h8000_0000_0000_0010, 64'hDEAD, 64'h0, 1'b1, 0);
    txn("load 0x10 after high", 1'b0, 64'h10, 64'h0, 64'h1122334455667788, 1'b0, 0);
    txn("store last word", 1'b1, 64'hF8, 64'hCAFE_F00D_1234_5678, 64'h0, 1'b0, 0);
    txn("load last word", 1'b0, 64'hF8, 64'h0, 64'hCAFE_F00D_1234_5678, 1'b0, 1);
    txn("oor load 0x100", 1'b0, 64'h100, 64'h0, 64'h0, 1'b1, 0);

`ifdef DATA_MEM_ALIGN_CHECK_EN
    txn("misaligned store", 1'b1, 64'h0B, 64'hAB, 64'h0, 1'b1, 0);
    txn("load 0x08", 1'b0, 64'h08, 64'h0, 64'h0, 1'b0, 0);
`else
    txn("misaligned store", 1'b1, 64'h0B, 64'hAB, 64'h0, 1'b0, 0);
    txn("load 0x08", 1'b0, 64'h08, 64'h0, 64'hAB, 1'b0, 0);
`endif

    // Reset while a store to 0x18 sits in WAIT.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h18;
    req_wdata = 64'h5;
    step();
    req_valid = 1'b0;
    check("abort in wait valid", 64'(rsp_valid), 64'd0);
    check("abort in wait req_ready", 64'(req_ready), 64'd0);
    reset = 1'b1;
    #1;
    check("abort async req_ready", 64'(req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort rsp_valid", 64'(rsp_valid), 64'd0);
    end
    reset = 1'b0;
    txn("load 0x18 after abort", 1'b0, 64'h18, 64'h0, 64'h0, 1'b0, 0);
    txn("load 0x10 after reset", 1'b0, 64'h10, 64'h0, 64'h0, 1'b0, 0);

    // LATENCY=1 instance: held req_valid gives re-accept on the edge after handshake.
    q_req_valid = 1'b1;
    q_req_write = 1'b1;
    q_req_addr  = 64'h18;
    q_req_wdata = 64'h77;
    step();
    check("lat1 accept req_ready", 64'(q_req_ready), 64'd0);
    check("lat1 accept rsp_valid", 64'(q_rsp_valid), 64'd0);
    step();
    check("lat1 rsp_valid", 64'(q_rsp_valid), 64'd1);
    check("lat1 store err", 64'(q_rsp_err), 64'd0);
    q_rsp_ready = 1'b1;
    step();
    q_rsp_ready = 1'b0;
    check("lat1 handshake valid", 64'(q_rsp_valid), 64'd0);
    check("lat1 handshake req_ready", 64'(q_req_ready), 64'd1);
    step();
    check("lat1 reaccept req_ready", 64'(q_req_ready), 64'd0);
    q_req_valid = 1'b0;
    step();
    check("lat1 second rsp_valid", 64'(q_rsp_valid), 64'd1);
    q_rsp_ready = 1'b1;
    step();
    q_rsp_ready = 1'b0;
    check("lat1 second done", 64'(q_req_ready), 64'd1);
    q_req_valid = 1'b1;
    q_req_write = 1'b0;
    step();
    q_req_valid = 1'b0;
    step();
    check("lat1 load valid", 64'(q_rsp_valid), 64'd1);
    check("lat1 load rdata", q_rsp_rdata, 64'h77);
    q_rsp_ready = 1'b1;
    step();
    q_rsp_ready = 1'b0;
    q_req_valid = 1'b1;
    q_req_addr  = 64'h20;
    step();
    q_req_valid = 1'b0;
    step();
    check("lat1 oor err", 64'(q_rsp_err), 64'd1);
    check("lat1 oor rdata", q_rsp_rdata, 64'h0);
    q_rsp_ready = 1'b1;
    step();
    q_rsp_ready = 1'b0;
    check("lat1 oor done", 64'(q_req_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
